// File: rtl/cpu_types_pkg.sv
// Shared core types: immediate format encoding and the base opcodes
// that select an immediate format.
package cpu_types_pkg;

   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_S  = 3'd2,
      FMT_B  = 3'd3,
      FMT_U  = 3'd4,
      FMT_J  = 3'd5,
      FMT_Z  = 3'd6,
      FMT_SH = 3'd7
   } imm_fmt_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_ext_decode.sv
// Combinational immediate decode: instruction word -> {format, XLEN-bit immediate}.
module imm_ext_decode
   import cpu_types_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   output imm_fmt_t        o_fmt,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_raw;
   logic [2:0]  w_f3;

   assign w_f3 = i_instr[14:12];

   // w_raw already carries the correct bit 31, so one sign extension covers
   // every format (zero-extended fields simply have bit 31 clear).
   always_comb begin
      o_fmt = FMT_R;
      w_raw = '0;
      case (i_instr[6:0])
         OPC_OP_IMM: begin
            if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
               o_fmt = FMT_SH;
               w_raw = (XLEN == 64) ? {26'b0, i_instr[25:20]} : {27'b0, i_instr[24:20]};
            end else begin
               o_fmt = FMT_I;
               w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
            end
         end
         OPC_LOAD, OPC_JALR: begin
            o_fmt = FMT_I;
            w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
         end
         OPC_STORE: begin
            o_fmt = FMT_S;
            w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         end
         OPC_BRANCH: begin
            o_fmt = FMT_B;
            w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            o_fmt = FMT_U;
            w_raw = {i_instr[31:12], 12'b0};
         end
         OPC_JAL: begin
            o_fmt = FMT_J;
            w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         end
         OPC_SYSTEM: begin
            if (w_f3[2]) begin
               o_fmt = FMT_Z;
               w_raw = {27'b0, i_instr[19:15]};
            end else begin
               o_fmt = FMT_I;
               w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
            end
         end
         default: begin
            o_fmt = FMT_R;
            w_raw = '0;
         end
      endcase
   end

   assign o_imm = XLEN'($signed(w_raw));

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-generation stage with valid/ready handshake and tag sideband.
// Optional macro IMM_EXT_SKID_EN adds a 2-entry skid buffer with registered in_ready.
module imm_ext_stage
   import cpu_types_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             nRst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output imm_fmt_t         out_fmt,
   output logic [TAG_W-1:0] out_tag
);

   imm_fmt_t         w_fmt;
   logic [XLEN-1:0]  w_imm;
   logic             w_acc;
   logic             r_vld;
   logic [XLEN-1:0]  r_imm;
   imm_fmt_t         r_fmt;
   logic [TAG_W-1:0] r_tag;

   imm_ext_decode #(.XLEN(XLEN)) u_dec (
      .i_instr (in_instr),
      .o_fmt   (w_fmt),
      .o_imm   (w_imm)
   );

   assign w_acc     = in_valid & in_ready;
   assign out_valid = r_vld;
   assign out_imm   = r_imm;
   assign out_fmt   = r_fmt;
   assign out_tag   = r_tag;

`ifdef IMM_EXT_SKID_EN
   logic             r_rdy;
   logic             r_s_vld;
   logic [XLEN-1:0]  r_s_imm;
   imm_fmt_t         r_s_fmt;
   logic [TAG_W-1:0] r_s_tag;
   logic             w_main_free;

   assign in_ready    = r_rdy;
   assign w_main_free = ~r_vld | out_ready;

   // Skid only fills while main is stalled; when main frees up the skid
   // entry moves in ahead of any new input (in_ready is low then anyway).
   always_ff @(posedge clk) begin
      if (!nRst) begin
         r_rdy   <= 1'b0;
         r_vld   <= 1'b0;
         r_imm   <= '0;
         r_fmt   <= FMT_R;
         r_tag   <= '0;
         r_s_vld <= 1'b0;
         r_s_imm <= '0;
         r_s_fmt <= FMT_R;
         r_s_tag <= '0;
      end else begin
         if (w_main_free) begin
            if (r_s_vld) begin
               r_vld   <= 1'b1;
               r_imm   <= r_s_imm;
               r_fmt   <= r_s_fmt;
               r_tag   <= r_s_tag;
               r_s_vld <= 1'b0;
            end else begin
               r_vld <= w_acc;
               if (w_acc) begin
                  r_imm <= w_imm;
                  r_fmt <= w_fmt;
                  r_tag <= in_tag;
               end
            end
         end else if (w_acc) begin
            r_s_vld <= 1'b1;
            r_s_imm <= w_imm;
            r_s_fmt <= w_fmt;
            r_s_tag <= in_tag;
         end
         r_rdy <= w_main_free | ~(r_s_vld | w_acc);
      end
   end
`else
   assign in_ready = nRst & (~r_vld | out_ready);

   always_ff @(posedge clk) begin
      if (!nRst) begin
         r_vld <= 1'b0;
         r_imm <= '0;
         r_fmt <= FMT_R;
         r_tag <= '0;
      end else if (w_acc) begin
         r_vld <= 1'b1;
         r_imm <= w_imm;
         r_fmt <= w_fmt;
         r_tag <= in_tag;
      end else if (out_ready) begin
         r_vld <= 1'b0;
      end
   end
`endif

endmodule
